shift_ctl: RTL and testbench

SHIFT_CTL -- requirements
Module: shift_ctl

---
 rtl/shift_ctl_if.sv | 30 +++
 rtl/shift_ctl.sv | 116 +++++++++++
 tb/tb_shift_ctl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_ctl_if.sv
// Command/status and slice-control bundle between a host and shift_ctl.
// The slave side is the controller; the master side drives commands and slice taps.
interface shift_ctl_if;
    logic       req;
    logic [2:0] cmd;
    logic [5:0] count;
    logic       fill;
    logic       abort;
    logic       head_q;
    logic       tail_q;
    logic       ack;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       err;
    logic       op2;
    logic       op1;
    logic       shft0in;
    logic       shft3in;

    modport master (
        output req, cmd, count, fill, abort, head_q, tail_q,
        input  ack, busy, done, aborted, err, op2, op1, shft0in, shft3in
    );

    modport slave (
        input  req, cmd, count, fill, abort, head_q, tail_q,
        output ack, busy, done, aborted, err, op2, op1, shft0in, shft3in
    );
endinterface

// File: rtl/shift_ctl.sv
// Sequencer for a chain of four-bit universal shift-register slices.
// Turns load/shift/rotate commands into per-cycle slice modes.
module shift_ctl (
    input  logic       clk,
    input  logic       reset,
    shift_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [2:0] C_LOAD = 3'b000;
    localparam logic [2:0] C_SHL  = 3'b001;
    localparam logic [2:0] C_SHR  = 3'b010;
    localparam logic [2:0] C_ROTL = 3'b011;
    localparam logic [2:0] C_ROTR = 3'b100;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_HOLD = 2'b11;

    state_t     st, st_n;
    logic [1:0] op_q, op_n;
    logic       busy_q;
    logic [5:0] rem_q, rem_n;
    logic [2:0] cmd_q, cmd_n;
    logic       fill_q, fill_n;
    logic       ill_q, ill_n;
    logic       abt_q, abt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= IDLE;
            op_q   <= OP_HOLD;
            busy_q <= 1'b0;
            rem_q  <= 6'd0;
            cmd_q  <= C_LOAD;
            fill_q <= 1'b0;
            ill_q  <= 1'b0;
            abt_q  <= 1'b0;
        end else begin
            st     <= st_n;
            op_q   <= op_n;
            busy_q <= (st_n != IDLE);
            rem_q  <= rem_n;
            cmd_q  <= cmd_n;
            fill_q <= fill_n;
            ill_q  <= ill_n;
            abt_q  <= abt_n;
        end
    end

    always_comb begin
        st_n   = st;
        op_n   = OP_HOLD;
        rem_n  = rem_q;
        cmd_n  = cmd_q;
        fill_n = fill_q;
        ill_n  = ill_q;
        abt_n  = abt_q;
        unique case (st)
            IDLE: begin
                if (bus.req) begin
                    cmd_n  = bus.cmd;
                    fill_n = bus.fill;
                    ill_n  = (bus.cmd > C_ROTR);
                    abt_n  = 1'b0;
                    if (bus.cmd > C_ROTR) begin
                        rem_n = 6'd0;
                        st_n  = FIN;
                    end else if (bus.cmd == C_LOAD) begin
                        rem_n = 6'd1;
                        op_n  = OP_LOAD;
                        st_n  = RUN;
                    end else if (bus.count == 6'd0) begin
                        rem_n = 6'd0;
                        st_n  = FIN;
                    end else begin
                        rem_n = bus.count;
                        st_n  = RUN;
                        if (bus.cmd == C_SHL || bus.cmd == C_ROTL)
                            op_n = OP_SHL;
                        else
                            op_n = OP_SHR;
                    end
                end
            end
            RUN: begin
                // the op presented this cycle is applied at the coming edge
                rem_n = (rem_q != 6'd0) ? rem_q - 6'd1 : 6'd0;
                if (bus.abort) begin
                    st_n  = FIN;
                    abt_n = 1'b1;
                end else if (rem_q <= 6'd1) begin
                    st_n = FIN;
                end else begin
                    op_n = op_q;
                end
            end
            FIN: st_n = IDLE;
            default: st_n = IDLE;
        endcase
    end

    assign bus.ack     = bus.req & (st == IDLE) & ~reset;
    assign bus.busy    = busy_q;
    assign bus.done    = (st == FIN) & ~abt_q & ~reset;
    assign bus.aborted = (st == FIN) & abt_q & ~reset;
    assign bus.err     = (st == FIN) & ill_q & ~reset;
    assign bus.op2     = op_q[1];
    assign bus.op1     = op_q[0];

    assign bus.shft0in = (cmd_q == C_SHL)  ? fill_q :
                         (cmd_q == C_ROTL) ? bus.tail_q : 1'b0;
    assign bus.shft3in = (cmd_q == C_SHR)  ? fill_q :
                         (cmd_q == C_ROTR) ? bus.head_q : 1'b0;
endmodule

// File: tb/tb_shift_ctl.sv
// Randomized bench for shift_ctl driving a 16-bit slice-chain plant.
// Expected results come from arithmetic load/shift/rotate rules.
module tb_shift_ctl;
    logic clk = 1'b0;
    logic reset;
    shift_ctl_if bus();

    shift_ctl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // four chained slices: shft0in enters bit 0, shft3in enters bit 15
    logic [15:0] v = 16'h0000;
    logic [15:0] ld_val = 16'h0000;

    always @(posedge clk) begin
        case ({bus.op2, bus.op1})
            2'b00: v <= ld_val;
            2'b10: v <= {v[14:0], bus.shft0in};
            2'b01: v <= {bus.shft3in, v[15:1]};
            default: ;
        endcase
    end

    assign bus.head_q = v[0];
    assign bus.tail_q = v[15];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_val(input logic [15:0] v0,
                                            input logic [2:0] c,
                                            input int n, input logic f,
                                            input logic [15:0] ld);
        logic [31:0] t;
        logic [31:0] m;
        int r;
        r = n % 16;
        case (c)
            3'd0: return ld;
            3'd1: begin
                t = {16'h0, v0} << n;
                m = f ? ((32'h1 << n) - 32'h1) : 32'h0;
                t = t | m;
                return t[15:0];
            end
            3'd2: begin
                t = {v0, 16'h0} >> n;
                m = f ? ~(32'hFFFF_FFFF >> n) : 32'h0;
                t = t | m;
                return t[31:16];
            end
            3'd3: begin
                t = {v0, v0} << r;
                return t[31:16];
            end
            3'd4: begin
                t = {v0, v0} >> r;
                return t[15:0];
            end
            default: return v0;
        endcase
    endfunction

    task automatic run(input string nm, input logic [2:0] c, input int n,
                       input logic f, input logic [15:0] ld,
                       input int ab, input int rs);
        int nops, nexp, opc, badop, badser;
        int busyc, donec, donecyc, abtc, errc, ackc;
        logic ill, es;
        logic [1:0] expop, op;
        logic [15:0] ve;
        opc = 0; badop = 0; badser = 0; busyc = 0;
        donec = 0; donecyc = -1; abtc = 0; errc = 0;
        ill = (c > 3'd4);
        nops = ill ? 0 : (c == 3'd0) ? 1 : n;
        nexp = (ab > 0) ? ab : (rs > 0) ? rs : nops;
        expop = (c == 3'd0) ? 2'b00 :
                (c == 3'd1 || c == 3'd3) ? 2'b10 : 2'b01;
        ld_val = ld;
        ve = ref_val(v, c, nexp, f, ld);

        bus.req = 1'b1;
        bus.cmd = c;
        bus.count = n[5:0];
        bus.fill = f;
        bus.abort = 1'($urandom_range(0, 1));
        reset = 1'b0;
        @(negedge clk);
        ackc = int'(bus.ack);
        if ({bus.op2, bus.op1} != 2'b11) badop++;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        bus.cmd = 3'($urandom);
        bus.count = 6'($urandom);
        bus.fill = 1'($urandom);

        for (int cyc = 1; cyc <= nops + 4; cyc++) begin
            bus.abort = (cyc == ab);
            reset = (cyc == rs);
            @(negedge clk);
            op = {bus.op2, bus.op1};
            if (cyc <= nexp) begin
                if (op != expop) badop++;
            end else if (op != 2'b11) badop++;
            if (op != 2'b11) begin
                opc++;
                if (c == 3'd1 || c == 3'd3) begin
                    es = (c == 3'd1) ? f : v[15];
                    if (bus.shft0in !== es) badser++;
                end
                if (c == 3'd2 || c == 3'd4) begin
                    es = (c == 3'd2) ? f : v[0];
                    if (bus.shft3in !== es) badser++;
                end
            end
            busyc += int'(bus.busy);
            if (bus.done) begin
                donec++;
                donecyc = cyc;
            end
            abtc += int'(bus.aborted);
            errc += int'(bus.err);
            ackc += int'(bus.ack);
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b0;
        reset = 1'b0;

        check({nm, " ack"}, ackc, 1);
        check({nm, " opcycles"}, opc, nexp);
        check({nm, " badop"}, badop, 0);
        check({nm, " serial"}, badser, 0);
        check({nm, " busy"}, busyc, (rs > 0) ? rs : nexp + 1);
        check({nm, " done"}, donec, (ab == 0 && rs == 0) ? 1 : 0);
        if (donec == 1)
            check({nm, " donecyc"}, donecyc, nexp + 1);
        check({nm, " aborted"}, abtc, (ab > 0) ? 1 : 0);
        check({nm, " err"}, errc, ill ? 1 : 0);
        check({nm, " value"}, v, ve);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int acks, first, second, n, ab, rs, nops;
        logic [2:0] c;

        reset = 1'b1;
        bus.req = 1'b1;
        bus.cmd = 3'd0;
        bus.count = 6'd0;
        bus.fill = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ack", bus.ack, 0);
        check("rst op", {bus.op2, bus.op1}, 2'b11);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst aborted", bus.aborted, 0);
        check("rst err", bus.err, 0);
        check("rst shft0in", bus.shft0in, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req = 1'b0;

        run("load0", 3'd0, 0, 1'b0, 16'h0000, 0, 0);
        run("shl5", 3'd1, 5, 1'b1, 16'h0, 0, 0);
        check("shl5 abs", v, 16'h001F);
        run("loadA5", 3'd0, 0, 1'b0, 16'hA5C3, 0, 0);
        run("rotr16", 3'd4, 16, 1'b0, 16'h0, 0, 0);
        check("rotr16 abs", v, 16'hA5C3);
        run("shr0", 3'd2, 0, 1'b1, 16'h0, 0, 0);
        run("ill", 3'd7, 9, 1'b1, 16'h0, 0, 0);
        run("shl10ab4", 3'd1, 10, 1'b1, 16'h0, 4, 0);
        run("shl10ab10", 3'd1, 10, 1'b0, 16'h0, 10, 0);
        run("loadF0", 3'd0, 0, 1'b0, 16'hF00F, 0, 0);
        run("shr8rs3", 3'd2, 8, 1'b1, 16'h0, 0, 3);
        run("after_rs", 3'd3, 7, 1'b0, 16'h0, 0, 0);

        // abort while idle has no effect
        bus.abort = 1'b1;
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        @(negedge clk);
        check("idle abort busy", bus.busy, 0);
        check("idle abort aborted", bus.aborted, 0);
        @(posedge clk);
        #1;

        // req held high: one accept every three cycles
        ld_val = 16'h1234;
        bus.req = 1'b1;
        bus.cmd = 3'd0;
        acks = 0;
        first = -1;
        second = -1;
        for (int cyc = 0; cyc < 7; cyc++) begin
            @(negedge clk);
            if (bus.ack) begin
                acks++;
                if (first < 0) first = cyc;
                else if (second < 0) second = cyc;
            end
            @(posedge clk);
            #1;
        end
        bus.req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("held acks", acks, 3);
        check("held gap", second - first, 3);
        check("held value", v, 16'h1234);

        for (int i = 0; i < 40; i++) begin
            c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7))
                                            : 3'($urandom_range(0, 4));
            n = ($urandom_range(0, 7) == 0) ? 63 : $urandom_range(0, 20);
            nops = (c > 3'd4) ? 0 : (c == 3'd0) ? 1 : n;
            ab = 0;
            rs = 0;
            if (nops > 0 && $urandom_range(0, 3) == 0)
                ab = $urandom_range(1, nops);
            else if (nops > 0 && $urandom_range(0, 5) == 0)
                rs = $urandom_range(1, nops);
            run($sformatf("rnd%0d", i), c, n, 1'($urandom),
                16'($urandom), ab, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
